regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// - Parametrised multi-port integer register file with a pending-write scoreboard.
// - Sits in ID/ID2EXE of the pipeline. Replaces the fixed 2R/1W file.
// - Adds: N read / M write ports, registered reads with stall-hold, write-first
//   bypass, and per-register busy bits for hazard detection.
// PARAMETERS
// - XLEN      32  data width in bits
// - NREGS     32  number of architectural registers; power of 2, >=2
// - NUM_RD     2  read ports, 1..4
// - NUM_WR     2  write ports, 1..2; a higher index has higher priority
// - ZERO_REG   1  1: reg 0 reads 0 and ignores writes and busy-set; 0: reg 0 is ordinary
// - localparam AW = $clog2(NREGS)
// PORTS
// - clk        in   1            rising-edge clock
// - rstn       in   1            synchronous active-low reset
// - rd_en      in   1            1: sample read addresses; 0: hold rd_data/rd_busy (stall)
// - rd_addr    in   NUM_RD*AW    read addresses; port k occupies [k*AW +: AW]
// - rd_data    out  NUM_RD*XLEN  registered read data, port k at [k*XLEN +: XLEN]
// - rd_busy    out  NUM_RD       registered busy bit of each read register
// - wr_en      in   NUM_WR       write enables
// - wr_addr    in   NUM_WR*AW    write addresses
// - wr_data    in   NUM_WR*XLEN  write data
// - bs_en      in   1            busy-set: a producer for bs_addr has been issued
// - bs_addr    in   AW           register to mark pending
// - any_busy   out  1            registered OR of all busy bits (drain/flush indication)
// BEHAVIOUR
// - All state is updated on posedge clk only. Reset is synchronous.
// - Reset (rstn=0 at an edge): every register = 0, all busy bits = 0, rd_data = 0,
//   rd_busy = 0, any_busy = 0.
// - Reset takes priority over every write, busy-set and read in that same cycle.
//   Reset asserted mid-operation discards pending writes.
// - Write: at an edge with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
//   If two write ports target the same address, port NUM_WR-1 wins.
// - Read: 1-cycle latency. At an edge with rd_en=1, rd_data[k] <= value(rd_addr[k]).
//   value() is write-first: if a write to that address is enabled at this same edge,
//   the winning write data is returned; otherwise the stored value is returned.
// - rd_en=0: rd_data and rd_busy keep their previous values. Writes and busy
//   updates still occur.
// - ZERO_REG=1: address 0 always reads 0 (including bypass) and rd_busy reads 0.
//   Writes and bs_en to address 0 are dropped.
// - Scoreboard, evaluated per register each edge:
//   - set = bs_en & (bs_addr==r); clr = any wr_en[j] & (wr_addr[j]==r).
//   - busy[r] <= set ? 1 : clr ? 0 : busy[r]. Set beats clear, because the newer
//     producer is still pending.
// - rd_busy[k] is sampled like rd_data: it is the busy value AFTER this edge's update.
//   A same-edge clear reads 0. A same-edge set reads 1.
// - any_busy is registered. It reflects the busy vector after the update at the
//   same edge.
// - Widths: no arithmetic. Out-of-range addresses cannot occur because NREGS is a power of 2.
// STRUCTURE
// - Package regfile_pkg: AW_OF(n) helper, reset constant XZERO, and the
//   NUM_RD/NUM_WR limit checks.
// - Sub-module regfile_scoreboard (NREGS, NUM_WR, ZERO_REG):
//   - holds the busy vector and any_busy;
//   - exposes a combinational next_busy vector, so read ports can sample the
//     post-update busy value.
// - Top level contains the data array, the write-priority mux, the bypass compare
//   and the output registers. Use generate loops over the port counts.
// TESTING
// - Reset: write reg5=0xA5A5A5A5, then pulse rstn=0 for 1 cycle, then read 5 ->
//   rd_data=0, rd_busy=0, any_busy=0.
// - Basic: write reg3=0x12345678. Next cycle read port0=3, port1=3 -> both ports
//   return 0x12345678 one cycle after the address edge.
// - Bypass/priority: at the same edge wr0 writes r7=0x11, wr1 writes r7=0x22, and
//   port0 reads r7 -> rd_data=0x22 at that edge; a later read of r7 also = 0x22.
// - Zero reg: write r0=0xFFFFFFFF with bs_en to r0 -> reading r0 gives 0, rd_busy=0,
//   any_busy=0.
// - Scoreboard:
//   - bs_en r9 -> next read of r9 gives rd_busy=1, any_busy=1.
//   - wr r9=0x5 with a same-edge read -> rd_data=0x5, rd_busy=0.
//   - bs_en and wr to r9 at the same edge -> busy stays 1.
// - Stall: read r4 (=0x44), then rd_en=0 while r4 is rewritten to 0x55 and the
//   address changes -> rd_data holds 0x44. With rd_en=1 -> 0x55 on the next edge.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// regfile_pkg: shared helpers, reset constant and port-count limits for regfile_mp
package regfile_pkg;
  localparam int MAX_RD = 4;
  localparam int MAX_WR = 2;
  localparam bit XZERO = 1'b0;
  function automatic int AW_OF(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic bit ports_ok(input int nrd, input int nwr);
    return nrd >= 1 && nrd <= MAX_RD && nwr >= 1 && nwr <= MAX_WR;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and busy-set bus of the multi-port register file
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  localparam int AW = AW_OF(NREGS);
  logic                   rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   bs_en;
  logic [AW-1:0]          bs_addr;
  logic                   any_busy;
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, bs_en, bs_addr,
    input  rd_data, rd_busy, any_busy
  );
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, bs_en, bs_addr,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits; set beats clear since the newer producer is still outstanding
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS    = 32,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = AW_OF(NREGS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic                 bs_en_i,
  input  logic [AW-1:0]        bs_addr_i,
  output logic [NREGS-1:0]     next_busy_o,
  output logic                 any_busy_o
);
  logic [NREGS-1:0] busy_q;
  logic             any_busy_q;
  always_comb begin
    next_busy_o = busy_q;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en_i[j]) next_busy_o[wr_addr_i[j*AW +: AW]] = 1'b0;
    if (bs_en_i && !(ZERO_REG != 0 && bs_addr_i == '0)) next_busy_o[bs_addr_i] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= next_busy_o;
      any_busy_q <= |next_busy_o;
    end
  end
  assign any_busy_o = any_busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: N-read/M-write register file with registered write-first reads, stall-hold and busy scoreboard
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic        clk,
  input logic        rstn,
  regfile_mp_if.slave bus
);
  localparam int AW = AW_OF(NREGS);
  if (!ports_ok(NUM_RD, NUM_WR)) begin : g_bad_ports
    $error("regfile_mp: NUM_RD must be 1..4 and NUM_WR 1..2");
  end
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] next_busy;
  // later ports overwrite earlier ones, so the highest enabled index wins; reads see regs_d (write-first)
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++)
      if (bus.wr_en[j] && !(ZERO_REG != 0 && bus.wr_addr[j*AW +: AW] == '0))
        regs_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
  end
  always_ff @(posedge clk) begin
    if (!rstn) regs_q <= '{default: {XLEN{XZERO}}};
    else regs_q <= regs_d;
  end
  regfile_scoreboard #(.NREGS(NREGS), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)) u_sb (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .bs_en_i    (bus.bs_en),
    .bs_addr_i  (bus.bs_addr),
    .next_busy_o(next_busy),
    .any_busy_o (bus.any_busy)
  );
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_d;
    logic            busy_q;
    logic            busy_d;
    logic [AW-1:0]   addr;
    assign addr   = bus.rd_addr[k*AW +: AW];
    assign data_d = bus.rd_en ? regs_d[addr] : data_q;
    assign busy_d = bus.rd_en ? next_busy[addr] : busy_q;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        data_q <= {XLEN{XZERO}};
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end
    assign bus.rd_data[k*XLEN +: XLEN] = data_q;
    assign bus.rd_busy[k]              = busy_q;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of reset, write-first reads, priority, zero reg, scoreboard and stall
module tb_regfile_mp;
  localparam int AW = 5;
  logic clk;
  logic rstn;
  int   tests;
  int   fails;
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) bus ();
  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.wr_en = '0;
    bus.bs_en = 1'b0;
  endtask
  task automatic wr(input int j, input logic [AW-1:0] a, input logic [31:0] d);
    bus.wr_en[j]              = 1'b1;
    bus.wr_addr[j*AW +: AW]   = a;
    bus.wr_data[j*32 +: 32]   = d;
  endtask
  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rd_en   = 1'b1;
    bus.rd_addr = {a1, a0};
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    rstn = 1'b0;
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.bs_en = 1'b0;
    bus.bs_addr = '0;
    tick();
    tick();
    chk("rst_rd_data", bus.rd_data[31:0], 32'h0);
    chk("rst_rd_busy", {30'b0, bus.rd_busy}, 32'h0);
    chk("rst_any_busy", {31'b0, bus.any_busy}, 32'h0);
    rstn = 1'b1;
    wr(0, 5, 32'hA5A5A5A5);
    tick();
    idle();
    rd(5, 5);
    tick();
    chk("pre_rst_r5", bus.rd_data[31:0], 32'hA5A5A5A5);
    rstn = 1'b0;
    tick();
    chk("rst_beats_read", bus.rd_data[31:0], 32'h0);
    rstn = 1'b1;
    tick();
    chk("post_rst_r5", bus.rd_data[31:0], 32'h0);
    chk("post_rst_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
    chk("post_rst_any", {31'b0, bus.any_busy}, 32'h0);
    bus.rd_en = 1'b0;
    wr(0, 3, 32'h12345678);
    tick();
    idle();
    rd(3, 3);
    tick();
    chk("basic_p0", bus.rd_data[31:0], 32'h12345678);
    chk("basic_p1", bus.rd_data[63:32], 32'h12345678);
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    rd(7, 3);
    tick();
    chk("bypass_prio_p0", bus.rd_data[31:0], 32'h22);
    chk("bypass_other_p1", bus.rd_data[63:32], 32'h12345678);
    idle();
    rd(3, 7);
    tick();
    chk("prio_stored_p1", bus.rd_data[63:32], 32'h22);
    wr(0, 0, 32'hFFFFFFFF);
    bus.bs_en = 1'b1;
    bus.bs_addr = 0;
    rd(0, 0);
    tick();
    chk("zero_bypass", bus.rd_data[31:0], 32'h0);
    idle();
    tick();
    chk("zero_stored", bus.rd_data[63:32], 32'h0);
    chk("zero_busy", {30'b0, bus.rd_busy}, 32'h0);
    chk("zero_any", {31'b0, bus.any_busy}, 32'h0);
    bus.bs_en = 1'b1;
    bus.bs_addr = 9;
    bus.rd_en = 1'b0;
    tick();
    idle();
    rd(9, 3);
    tick();
    chk("sb_set_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
    chk("sb_other_idle", {31'b0, bus.rd_busy[1]}, 32'h0);
    chk("sb_set_any", {31'b0, bus.any_busy}, 32'h1);
    wr(1, 9, 32'h5);
    tick();
    idle();
    chk("sb_clr_data", bus.rd_data[31:0], 32'h5);
    chk("sb_clr_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
    chk("sb_clr_any", {31'b0, bus.any_busy}, 32'h0);
    wr(0, 9, 32'h6);
    bus.bs_en = 1'b1;
    bus.bs_addr = 9;
    tick();
    idle();
    chk("sb_both_data", bus.rd_data[31:0], 32'h6);
    chk("sb_both_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
    chk("sb_both_any", {31'b0, bus.any_busy}, 32'h1);
    tick();
    chk("sb_still_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
    wr(0, 9, 32'h7);
    wr(1, 4, 32'h44);
    bus.rd_en = 1'b0;
    tick();
    idle();
    rd(4, 9);
    tick();
    chk("stall_pre_p0", bus.rd_data[31:0], 32'h44);
    chk("stall_pre_p1", bus.rd_data[63:32], 32'h7);
    bus.rd_en = 1'b0;
    bus.rd_addr = {5'd3, 5'd3};
    wr(0, 4, 32'h55);
    bus.bs_en = 1'b1;
    bus.bs_addr = 9;
    tick();
    idle();
    chk("stall_hold_p0", bus.rd_data[31:0], 32'h44);
    chk("stall_hold_busy", {31'b0, bus.rd_busy[1]}, 32'h0);
    chk("stall_any_upd", {31'b0, bus.any_busy}, 32'h1);
    rd(4, 9);
    tick();
    chk("stall_release", bus.rd_data[31:0], 32'h55);
    chk("stall_rel_busy", {31'b0, bus.rd_busy[1]}, 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
